// File: rtl/bus_slave_endpoint.sv
// bus_slave_endpoint
// Target-side endpoint of the shell interconnect. Address and write data
// arrive over the shared "common" bus. Each transaction becomes one
// request/acknowledge access toward the user registers. A wait counter
// aborts any access that is not acknowledged in time, so the bus cannot hang.
module bus_slave_endpoint #(
    parameter int               WIDTH          = 32,
    parameter int               TIMEOUT_CYCLES = 256,
    parameter logic [WIDTH-1:0] ERR_DATA       = WIDTH'(32'hDEAD_BEEF)
) (
    input  logic             clk,
    input  logic             reset,

    // Controller side: address / write-data phases over the common bus
    input  logic             i_addr_valid,
    input  logic             i_write_enable,
    input  logic             i_write_data_valid,
    output logic             o_addr_ready,
    output logic             o_write_data_ready,
    input  logic [WIDTH-1:0] i_common,

    // Controller side: read response
    output logic             o_read_data_valid,
    input  logic             i_read_data_ready,
    output logic [WIDTH-1:0] o_read_data,

    // User register side: single request / acknowledge access
    output logic             o_req,
    output logic             o_req_we,
    output logic [WIDTH-1:0] o_req_addr,
    output logic [WIDTH-1:0] o_req_wdata,
    input  logic             i_req_ack,
    input  logic [WIDTH-1:0] i_req_rdata,

    // Status
    output logic [7:0]       o_timeout_count,
    output logic             o_busy
);

    // The wait counter only has to reach TIMEOUT_CYCLES-1.
    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        REQ   = 2'd2,
        RRESP = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] addr_q;
    logic             we_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [7:0]       tcount_q;

    logic             addr_hs;
    logic             wdata_hs;
    logic             ack_hit;
    logic             timeout_hit;
    logic             rresp_hs;

    // Saturating increment for the aborted-access counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Handshake and completion events, all qualified by the registered state.
    // An ack on the last wait cycle takes priority over the timeout.
    always_comb begin
        addr_hs     = (state_q == IDLE)  && i_addr_valid;
        wdata_hs    = (state_q == WDATA) && i_write_data_valid;
        ack_hit     = (state_q == REQ)   && i_req_ack;
        timeout_hit = (state_q == REQ)   && !i_req_ack && (wait_cnt_q == CNT_LAST);
        rresp_hs    = (state_q == RRESP) && i_read_data_ready;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (addr_hs) begin
                    state_d = i_write_enable ? WDATA : REQ;
                end
            end
            WDATA: begin
                if (wdata_hs) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // Writes finish here, reads always deliver a response (real or ERR_DATA).
                if (ack_hit || timeout_hit) begin
                    state_d = we_q ? IDLE : RRESP;
                end
            end
            RRESP: begin
                if (rresp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the registered state only.
    always_comb begin
        o_addr_ready       = 1'b0;
        o_write_data_ready = 1'b0;
        o_req              = 1'b0;
        o_read_data_valid  = 1'b0;
        unique case (state_q)
            IDLE:    o_addr_ready       = 1'b1;
            WDATA:   o_write_data_ready = 1'b1;
            REQ:     o_req              = 1'b1;
            RRESP:   o_read_data_valid  = 1'b1;
            default: o_addr_ready       = 1'b0;
        endcase
        o_busy = (state_q != IDLE);
    end

    // Address and direction are captured only on the address handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            we_q   <= 1'b0;
        end else if (addr_hs) begin
            addr_q <= i_common;
            we_q   <= i_write_enable;
        end
    end

    // Write data is captured only on the write-data handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdata_q <= '0;
        end else if (wdata_hs) begin
            wdata_q <= i_common;
        end
    end

    // Read data: user data on ack, error pattern on timeout, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (!we_q) begin
            if (ack_hit) begin
                rdata_q <= i_req_rdata;
            end else if (timeout_hit) begin
                rdata_q <= ERR_DATA;
            end
        end
    end

    // Wait counter: zero outside REQ, so it starts from zero on every REQ entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else if (state_q == REQ) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_q <= '0;
        end
    end

    // Count aborted accesses, saturating so the counter never wraps back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcount_q <= 8'd0;
        end else if (timeout_hit) begin
            tcount_q <= sat_inc8(tcount_q);
        end
    end

    assign o_req_addr      = addr_q;
    assign o_req_we        = we_q;
    assign o_req_wdata     = wdata_q;
    assign o_read_data     = rdata_q;
    assign o_timeout_count = tcount_q;

endmodule
